// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the cpu-to-system-memory arbiter slice.
package cpu_pkg;

    typedef enum logic {
        MASTER_ICACHE = 1'b0,
        MASTER_DCACHE = 1'b1
    } master_id_t;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic        burst;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

    // One in-flight read: who issued it and how many beats it returns.
    typedef struct packed {
        master_id_t id;
        logic       burst;
    } route_t;

endpackage

// File: rtl/cpu_route_fifo.sv
// cpu_route_fifo: in-order FIFO of outstanding read owners.
// Accepts a push into a full FIFO only when a pop frees the slot in the same cycle.
module cpu_route_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  route_t        push_data,
    input  logic          pop,
    output route_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    route_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end

    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= push_data;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin merge of icache/dcache memory traffic into one
// registered system-memory request, with in-order read responses routed back.
module cpu_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_mem_request,
    output logic        icache_mem_ready,
    input  logic        icache_mem_write,
    input  logic [31:0] icache_mem_address,
    input  logic        icache_mem_burst,
    input  logic [3:0]  icache_mem_wstrb,
    input  logic [31:0] icache_mem_wdata,
    output logic        icache_mem_rvalid,
    output logic [31:0] icache_mem_rdata,
    output logic [8:0]  icache_mem_rtag,
    input  logic        dcache_mem_request,
    output logic        dcache_mem_ready,
    input  logic        dcache_mem_write,
    input  logic [31:0] dcache_mem_address,
    input  logic        dcache_mem_burst,
    input  logic [3:0]  dcache_mem_wstrb,
    input  logic [31:0] dcache_mem_wdata,
    output logic        dcache_mem_rvalid,
    output logic [31:0] dcache_mem_rdata,
    output logic [8:0]  dcache_mem_rtag,
    output logic        sys_mem_request,
    input  logic        sys_mem_ready,
    output logic        sys_mem_write,
    output logic [31:0] sys_mem_address,
    output logic        sys_mem_burst,
    output logic [3:0]  sys_mem_wstrb,
    output logic [31:0] sys_mem_wdata,
    input  logic        sys_mem_rvalid,
    input  logic [31:0] sys_mem_rdata,
    input  logic [8:0]  sys_mem_rtag
);
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    mem_req_t      stage, icache_req, dcache_req;
    master_id_t    stage_id, rr_last, winner;
    route_t        head, push_data;
    logic          stage_valid, can_load, accept, push, pop, room, beat_last;
    logic          icache_elig, dcache_elig, full, empty;
    logic [CW-1:0] count;
    logic [CW:0]   in_flight;
    logic [BW-1:0] beat;

    assign icache_req = {icache_mem_write, icache_mem_address, icache_mem_burst, icache_mem_wstrb, icache_mem_wdata};
    assign dcache_req = {dcache_mem_write, dcache_mem_address, dcache_mem_burst, dcache_mem_wstrb, dcache_mem_wdata};

    assign push      = stage_valid && !stage.write && sys_mem_ready;
    assign push_data = {stage_id, stage.burst};
    assign beat_last = !head.burst || beat == BW'(BURST_LEN - 1);
    assign pop       = sys_mem_rvalid && !empty && beat_last;

    // Read slots reserved after this cycle's push/pop; a pop frees room for an accept in the same cycle.
    assign in_flight = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign room      = full ? (pop && !push) : (in_flight < (CW+1)'(MAX_OUTSTANDING));

    assign icache_elig = icache_mem_request && (icache_mem_write || room);
    assign dcache_elig = dcache_mem_request && (dcache_mem_write || room);
    assign winner      = (dcache_elig && (!icache_elig || rr_last == MASTER_ICACHE)) ? MASTER_DCACHE : MASTER_ICACHE;
    assign can_load    = !stage_valid || sys_mem_ready;
    assign accept      = (icache_elig || dcache_elig) && can_load;

    assign icache_mem_ready = !reset && accept && winner == MASTER_ICACHE;
    assign dcache_mem_ready = !reset && accept && winner == MASTER_DCACHE;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            stage_valid <= 1'b0;
            stage       <= '0;
            stage_id    <= MASTER_ICACHE;
            rr_last     <= MASTER_DCACHE;
        end else if (can_load) begin
            stage_valid <= accept;
            if (accept) begin
                stage    <= winner == MASTER_ICACHE ? icache_req : dcache_req;
                stage_id <= winner;
                rr_last  <= winner;
            end
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) beat <= '0;
        else if (sys_mem_rvalid && !empty) beat <= pop ? '0 : beat + 1'b1;

    cpu_route_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign sys_mem_request = stage_valid;
    assign {sys_mem_write, sys_mem_address, sys_mem_burst, sys_mem_wstrb, sys_mem_wdata} = stage;

    // Beats arriving with no outstanding read are dropped.
    assign icache_mem_rvalid = sys_mem_rvalid && !empty && head.id == MASTER_ICACHE;
    assign dcache_mem_rvalid = sys_mem_rvalid && !empty && head.id == MASTER_DCACHE;
    assign icache_mem_rdata  = reset ? '0 : sys_mem_rdata;
    assign dcache_mem_rdata  = reset ? '0 : sys_mem_rdata;
    assign icache_mem_rtag   = reset ? '0 : sys_mem_rtag;
    assign dcache_mem_rtag   = reset ? '0 : sys_mem_rtag;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed scenarios plus a randomized run checked
// against a queue-based transaction model of the arbiter.
module tb_cpu_mem_arbiter;
    localparam int BL = 8;
    localparam int MO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        icache_mem_request, icache_mem_ready, icache_mem_write, icache_mem_burst, icache_mem_rvalid;
    logic [31:0] icache_mem_address, icache_mem_wdata, icache_mem_rdata;
    logic [3:0]  icache_mem_wstrb;
    logic [8:0]  icache_mem_rtag;
    logic        dcache_mem_request, dcache_mem_ready, dcache_mem_write, dcache_mem_burst, dcache_mem_rvalid;
    logic [31:0] dcache_mem_address, dcache_mem_wdata, dcache_mem_rdata;
    logic [3:0]  dcache_mem_wstrb;
    logic [8:0]  dcache_mem_rtag;
    logic        sys_mem_request, sys_mem_ready, sys_mem_write, sys_mem_burst, sys_mem_rvalid;
    logic [31:0] sys_mem_address, sys_mem_wdata, sys_mem_rdata;
    logic [3:0]  sys_mem_wstrb;
    logic [8:0]  sys_mem_rtag;
    logic [156:0] all_out;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        id;
        logic        write;
        logic [31:0] addr;
        logic        burst;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic       id;
        logic [4:0] left;
    } flight_t;

    always #5 clock = ~clock;

    cpu_mem_arbiter #(.BURST_LEN(BL), .MAX_OUTSTANDING(MO)) dut (
        .clock              (clock),
        .reset              (reset),
        .icache_mem_request (icache_mem_request),
        .icache_mem_ready   (icache_mem_ready),
        .icache_mem_write   (icache_mem_write),
        .icache_mem_address (icache_mem_address),
        .icache_mem_burst   (icache_mem_burst),
        .icache_mem_wstrb   (icache_mem_wstrb),
        .icache_mem_wdata   (icache_mem_wdata),
        .icache_mem_rvalid  (icache_mem_rvalid),
        .icache_mem_rdata   (icache_mem_rdata),
        .icache_mem_rtag    (icache_mem_rtag),
        .dcache_mem_request (dcache_mem_request),
        .dcache_mem_ready   (dcache_mem_ready),
        .dcache_mem_write   (dcache_mem_write),
        .dcache_mem_address (dcache_mem_address),
        .dcache_mem_burst   (dcache_mem_burst),
        .dcache_mem_wstrb   (dcache_mem_wstrb),
        .dcache_mem_wdata   (dcache_mem_wdata),
        .dcache_mem_rvalid  (dcache_mem_rvalid),
        .dcache_mem_rdata   (dcache_mem_rdata),
        .dcache_mem_rtag    (dcache_mem_rtag),
        .sys_mem_request    (sys_mem_request),
        .sys_mem_ready      (sys_mem_ready),
        .sys_mem_write      (sys_mem_write),
        .sys_mem_address    (sys_mem_address),
        .sys_mem_burst      (sys_mem_burst),
        .sys_mem_wstrb      (sys_mem_wstrb),
        .sys_mem_wdata      (sys_mem_wdata),
        .sys_mem_rvalid     (sys_mem_rvalid),
        .sys_mem_rdata      (sys_mem_rdata),
        .sys_mem_rtag       (sys_mem_rtag)
    );

    assign all_out = {icache_mem_ready, icache_mem_rvalid, icache_mem_rdata, icache_mem_rtag,
                      dcache_mem_ready, dcache_mem_rvalid, dcache_mem_rdata, dcache_mem_rtag,
                      sys_mem_request, sys_mem_write, sys_mem_address, sys_mem_burst, sys_mem_wstrb, sys_mem_wdata};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        icache_mem_request = 0; icache_mem_write = 0; icache_mem_address = '0; icache_mem_burst = 0;
        icache_mem_wstrb = '0; icache_mem_wdata = '0;
        dcache_mem_request = 0; dcache_mem_write = 0; dcache_mem_address = '0; dcache_mem_burst = 0;
        dcache_mem_wstrb = '0; dcache_mem_wdata = '0;
        sys_mem_ready = 0; sys_mem_rvalid = 0; sys_mem_rdata = '0; sys_mem_rtag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        icache_mem_request = 1; dcache_mem_request = 1; sys_mem_ready = 1;
        sys_mem_rvalid = 1; sys_mem_rdata = '1; sys_mem_rtag = '1;
        #12;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        sys_mem_ready = 1;
        icache_mem_request = 1; icache_mem_address = 32'h100;
        @(negedge clock);
        vectors++;
        if ({icache_mem_ready, dcache_mem_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 10", {icache_mem_ready, dcache_mem_ready});
        end
        tick();
        icache_mem_request = 0;
        @(negedge clock);
        vectors++;
        if ({sys_mem_request, sys_mem_write, sys_mem_burst, sys_mem_address} !== {3'b100, 32'h100}) begin
            miscompares++;
            $display("FAIL single_sysreq: got %b %b %b %h want 1 0 0 00000100",
                     sys_mem_request, sys_mem_write, sys_mem_burst, sys_mem_address);
        end
        tick();
        sys_mem_rvalid = 1; sys_mem_rdata = 32'hDEADBEEF; sys_mem_rtag = 9'h05;
        @(negedge clock);
        vectors++;
        if ({icache_mem_rvalid, dcache_mem_rvalid, icache_mem_rdata, icache_mem_rtag, sys_mem_request} !==
            {2'b10, 32'hDEADBEEF, 9'h05, 1'b0}) begin
            miscompares++;
            $display("FAIL single_resp: got rv=%b%b data=%h tag=%h req=%b want 10 deadbeef 005 0",
                     icache_mem_rvalid, dcache_mem_rvalid, icache_mem_rdata, icache_mem_rtag, sys_mem_request);
        end
        tick();
        idle();
    endtask

    task automatic test_alternate();
        logic [31:0] ia, da;
        logic [31:0] addr_q[$];
        logic        id_q[$];
        logic        route_q[$];
        logic        rv;
        logic [1:0]  exp;
        ia = 32'h1000; da = 32'h2000;
        do_reset();
        sys_mem_ready = 1;
        for (int k = 0; k < 10; k++) begin
            icache_mem_request = k < 6; dcache_mem_request = k < 6;
            icache_mem_address = ia; dcache_mem_address = da;
            rv = route_q.size() > 0;
            sys_mem_rvalid = rv; sys_mem_rdata = 32'hC000_0000 + k;
            @(negedge clock);
            exp = k >= 6 ? 2'b00 : (k % 2 == 0 ? 2'b10 : 2'b01);
            vectors++;
            if ({icache_mem_ready, dcache_mem_ready} !== exp) begin
                miscompares++;
                $display("FAIL alt_grant[%0d]: got %b want %b", k, {icache_mem_ready, dcache_mem_ready}, exp);
            end
            if (rv) begin
                vectors++;
                if ({icache_mem_rvalid, dcache_mem_rvalid} !== (route_q[0] ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL alt_route[%0d]: got %b want owner %0d", k,
                             {icache_mem_rvalid, dcache_mem_rvalid}, route_q[0]);
                end
                void'(route_q.pop_front());
            end
            if (addr_q.size() > 0) begin
                vectors++;
                if (sys_mem_request !== 1'b1 || sys_mem_address !== addr_q[0]) begin
                    miscompares++;
                    $display("FAIL alt_addr[%0d]: got %b %h want 1 %h", k, sys_mem_request, sys_mem_address, addr_q[0]);
                end
                route_q.push_back(id_q[0]);
                void'(addr_q.pop_front());
                void'(id_q.pop_front());
            end
            if (icache_mem_ready) begin addr_q.push_back(ia); id_q.push_back(1'b0); ia += 4; end
            if (dcache_mem_ready) begin addr_q.push_back(da); id_q.push_back(1'b1); da += 4; end
            tick();
        end
        sys_mem_rvalid = 0;
        vectors++;
        if (sys_mem_request !== 1'b0 || route_q.size() != 0 || ia != 32'h100C || da != 32'h200C) begin
            miscompares++;
            $display("FAIL alt_drain: req=%b left=%0d ia=%h da=%h want 0 0 100c 200c",
                     sys_mem_request, route_q.size(), ia, da);
        end
        idle();
    endtask

    task automatic test_burst();
        do_reset();
        sys_mem_ready = 1;
        dcache_mem_request = 1; dcache_mem_address = 32'h2000; dcache_mem_burst = 1;
        @(negedge clock);
        vectors++;
        if ({icache_mem_ready, dcache_mem_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL burst_dgrant: got %b want 01", {icache_mem_ready, dcache_mem_ready});
        end
        tick();
        dcache_mem_request = 0; dcache_mem_burst = 0;
        icache_mem_request = 1; icache_mem_address = 32'h40;
        @(negedge clock);
        vectors++;
        if ({icache_mem_ready, dcache_mem_ready, sys_mem_request, sys_mem_burst, sys_mem_address} !== {4'b1011, 32'h2000}) begin
            miscompares++;
            $display("FAIL burst_igrant: got %b%b %b %b %h want 10 1 1 00002000", icache_mem_ready,
                     dcache_mem_ready, sys_mem_request, sys_mem_burst, sys_mem_address);
        end
        tick();
        icache_mem_request = 0;
        for (int b = 0; b < BL + 1; b++) begin
            sys_mem_rvalid = 1; sys_mem_rdata = 32'hB0 + b;
            @(negedge clock);
            vectors++;
            if ({icache_mem_rvalid, dcache_mem_rvalid} !== (b < BL ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL burst_beat[%0d]: got %b want %b", b, {icache_mem_rvalid, dcache_mem_rvalid},
                         b < BL ? 2'b01 : 2'b10);
            end
            tick();
        end
        sys_mem_rvalid = 0;
        vectors++;
        if (dut.u_fifo.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_empty: got %b want 1", dut.u_fifo.empty);
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        sys_mem_ready = 1;
        for (int k = 0; k < 4; k++) begin
            icache_mem_request = 1; icache_mem_address = 32'h300 + 4 * k;
            @(negedge clock);
            vectors++;
            if (icache_mem_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_issue[%0d]: got %b want 1", k, icache_mem_ready);
            end
            tick();
        end
        sys_mem_ready = 0; icache_mem_address = 32'h400;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            vectors++;
            if ({icache_mem_ready, sys_mem_request, sys_mem_address} !== {2'b01, 32'h30C}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %b %b %h want 0 1 0000030c", k, icache_mem_ready,
                         sys_mem_request, sys_mem_address);
            end
            tick();
        end
        sys_mem_ready = 1;
        @(negedge clock);
        vectors++;
        if (icache_mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full_push: got %b want 0", icache_mem_ready);
        end
        tick();
        @(negedge clock);
        vectors++;
        if (icache_mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got %b want 0", icache_mem_ready);
        end
        sys_mem_rvalid = 1; sys_mem_rdata = 32'hA0;
        #1;
        vectors++;
        if ({icache_mem_ready, icache_mem_rvalid} !== 2'b11) begin
            miscompares++;
            $display("FAIL bp_pop_accept: got %b want 11", {icache_mem_ready, icache_mem_rvalid});
        end
        tick();
        icache_mem_request = 0;
        for (int k = 0; k < 4; k++) begin
            sys_mem_rvalid = 1; sys_mem_rdata = 32'hA1 + k;
            @(negedge clock);
            vectors++;
            if ({icache_mem_rvalid, dcache_mem_rvalid} !== 2'b10) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got %b want 10", k, {icache_mem_rvalid, dcache_mem_rvalid});
            end
            tick();
        end
        sys_mem_rvalid = 0;
        vectors++;
        if ({dut.u_fifo.empty, sys_mem_request} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_end: got %b want 10", {dut.u_fifo.empty, sys_mem_request});
        end
        idle();
    endtask

    task automatic test_write();
        do_reset();
        sys_mem_ready = 1;
        dcache_mem_request = 1; dcache_mem_write = 1; dcache_mem_address = 32'h80;
        dcache_mem_wstrb = 4'b0011; dcache_mem_wdata = 32'h12345678;
        icache_mem_request = 1; icache_mem_address = 32'h44;
        @(negedge clock);
        vectors++;
        if ({icache_mem_ready, dcache_mem_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_first: got %b want 10", {icache_mem_ready, dcache_mem_ready});
        end
        tick();
        icache_mem_request = 0;
        @(negedge clock);
        vectors++;
        if ({icache_mem_ready, dcache_mem_ready, sys_mem_request, sys_mem_write, sys_mem_address} !== {4'b0110, 32'h44}) begin
            miscompares++;
            $display("FAIL wr_second: got %b%b %b %b %h want 01 1 0 00000044", icache_mem_ready,
                     dcache_mem_ready, sys_mem_request, sys_mem_write, sys_mem_address);
        end
        tick();
        dcache_mem_request = 0;
        @(negedge clock);
        vectors++;
        if ({sys_mem_request, sys_mem_write, sys_mem_address, sys_mem_burst, sys_mem_wstrb, sys_mem_wdata} !==
            {2'b11, 32'h80, 1'b0, 4'b0011, 32'h12345678}) begin
            miscompares++;
            $display("FAIL wr_fields: got %b %b %h %b %b %h want 1 1 00000080 0 0011 12345678", sys_mem_request,
                     sys_mem_write, sys_mem_address, sys_mem_burst, sys_mem_wstrb, sys_mem_wdata);
        end
        sys_mem_rvalid = 1; sys_mem_rdata = 32'h55;
        #1;
        vectors++;
        if ({icache_mem_rvalid, dcache_mem_rvalid, icache_mem_rdata} !== {2'b10, 32'h55}) begin
            miscompares++;
            $display("FAIL wr_route: got %b%b %h want 10 00000055", icache_mem_rvalid, dcache_mem_rvalid, icache_mem_rdata);
        end
        tick();
        sys_mem_rvalid = 0;
        vectors++;
        if (dut.u_fifo.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_nopush: got %b want 1", dut.u_fifo.empty);
        end
        idle();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        sys_mem_ready = 1;
        dcache_mem_request = 1; dcache_mem_address = 32'h2000; dcache_mem_burst = 1;
        tick();
        idle();
        sys_mem_ready = 1;
        tick();
        for (int b = 0; b < 3; b++) begin
            sys_mem_rvalid = 1;
            tick();
        end
        reset = 1;
        icache_mem_request = 1; dcache_mem_request = 1; sys_mem_rdata = '1; sys_mem_rtag = '1;
        #1;
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL midburst_reset: got %h want 0", all_out);
        end
        tick();
        idle();
        tick();
        reset = 0;
        sys_mem_ready = 1;
        icache_mem_request = 1; icache_mem_address = 32'h500; icache_mem_burst = 1;
        tick();
        icache_mem_request = 0; icache_mem_burst = 0;
        tick();
        for (int b = 0; b < BL; b++) begin
            sys_mem_rvalid = 1; sys_mem_rdata = 32'hE0 + b;
            @(negedge clock);
            vectors++;
            if ({icache_mem_rvalid, dcache_mem_rvalid} !== 2'b10) begin
                miscompares++;
                $display("FAIL fresh_beat[%0d]: got %b want 10", b, {icache_mem_rvalid, dcache_mem_rvalid});
            end
            tick();
            vectors++;
            if (dut.u_fifo.empty !== (b == BL - 1)) begin
                miscompares++;
                $display("FAIL fresh_pop[%0d]: empty got %b want %b", b, dut.u_fifo.empty, b == BL - 1);
            end
        end
        idle();
    endtask

    task automatic test_random();
        txn_t    pend[$];
        flight_t fl[$];
        flight_t f;
        txn_t    ti, td, t;
        logic    last, stage_busy, push_now, pop_now, room, ei, ed, can_load, any, win, rv, drain;
        logic [1:0] exp_ready, exp_rv;
        int      in_flight;
        last = 1'b1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drain = c >= 340;
            ti.id = 1'b0; ti.write = $urandom_range(0, 3) == 0; ti.addr = $urandom;
            ti.burst = !ti.write && $urandom_range(0, 2) == 0; ti.wstrb = 4'($urandom); ti.wdata = $urandom;
            td.id = 1'b1; td.write = $urandom_range(0, 3) == 0; td.addr = $urandom;
            td.burst = !td.write && $urandom_range(0, 2) == 0; td.wstrb = 4'($urandom); td.wdata = $urandom;
            icache_mem_request = !drain && $urandom_range(0, 9) < 6;
            {icache_mem_write, icache_mem_address, icache_mem_burst, icache_mem_wstrb, icache_mem_wdata} =
                {ti.write, ti.addr, ti.burst, ti.wstrb, ti.wdata};
            dcache_mem_request = !drain && $urandom_range(0, 9) < 6;
            {dcache_mem_write, dcache_mem_address, dcache_mem_burst, dcache_mem_wstrb, dcache_mem_wdata} =
                {td.write, td.addr, td.burst, td.wstrb, td.wdata};
            sys_mem_ready = drain || $urandom_range(0, 9) < 7;
            rv = fl.size() > 0 && (drain || $urandom_range(0, 9) < 6);
            sys_mem_rvalid = rv; sys_mem_rdata = $urandom; sys_mem_rtag = 9'($urandom);
            @(negedge clock);
            stage_busy = pend.size() > 0;
            push_now = 1'b0;
            if (stage_busy) push_now = !pend[0].write && sys_mem_ready;
            pop_now = 1'b0;
            if (rv) pop_now = fl[0].left == 5'd1;
            in_flight = fl.size() + int'(push_now) - int'(pop_now);
            room = in_flight < MO;
            ei = icache_mem_request && (icache_mem_write || room);
            ed = dcache_mem_request && (dcache_mem_write || room);
            can_load = !stage_busy || sys_mem_ready;
            any = can_load && (ei || ed);
            win = (ei && ed) ? !last : ed;
            exp_ready = any ? (win ? 2'b01 : 2'b10) : 2'b00;
            vectors++;
            if ({icache_mem_ready, dcache_mem_ready} !== exp_ready) begin
                miscompares++;
                $display("FAIL rnd_grant[%0d]: got %b want %b", c, {icache_mem_ready, dcache_mem_ready}, exp_ready);
            end
            vectors++;
            if (sys_mem_request !== stage_busy) begin
                miscompares++;
                $display("FAIL rnd_sysreq[%0d]: got %b want %b", c, sys_mem_request, stage_busy);
            end
            if (stage_busy) begin
                vectors++;
                if ({sys_mem_write, sys_mem_address, sys_mem_burst, sys_mem_wstrb, sys_mem_wdata} !==
                    {pend[0].write, pend[0].addr, pend[0].burst, pend[0].wstrb, pend[0].wdata}) begin
                    miscompares++;
                    $display("FAIL rnd_fields[%0d]: got %b %h %b %h %h want %b %h %b %h %h", c, sys_mem_write,
                             sys_mem_address, sys_mem_burst, sys_mem_wstrb, sys_mem_wdata, pend[0].write,
                             pend[0].addr, pend[0].burst, pend[0].wstrb, pend[0].wdata);
                end
            end
            exp_rv = 2'b00;
            if (rv) exp_rv = fl[0].id ? 2'b01 : 2'b10;
            vectors++;
            if ({icache_mem_rvalid, dcache_mem_rvalid} !== exp_rv) begin
                miscompares++;
                $display("FAIL rnd_route[%0d]: got %b want %b", c, {icache_mem_rvalid, dcache_mem_rvalid}, exp_rv);
            end
            vectors++;
            if ({icache_mem_rdata, dcache_mem_rdata, icache_mem_rtag, dcache_mem_rtag} !==
                {sys_mem_rdata, sys_mem_rdata, sys_mem_rtag, sys_mem_rtag}) begin
                miscompares++;
                $display("FAIL rnd_bcast[%0d]: got %h %h %h %h want %h %h", c, icache_mem_rdata, dcache_mem_rdata,
                         icache_mem_rtag, dcache_mem_rtag, sys_mem_rdata, sys_mem_rtag);
            end
            if (rv) begin
                f = fl.pop_front();
                f.left = f.left - 5'd1;
                if (f.left != 0) fl.push_front(f);
            end
            if (stage_busy && sys_mem_ready) begin
                t = pend.pop_front();
                if (!t.write) begin
                    f.id = t.id;
                    f.left = t.burst ? 5'(BL) : 5'd1;
                    fl.push_back(f);
                end
            end
            if (any) begin
                pend.push_back(win ? td : ti);
                last = win;
            end
            tick();
        end
        idle();
        vectors++;
        if (pend.size() != 0 || fl.size() != 0 || sys_mem_request !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_drain: pending=%0d inflight=%0d req=%b want 0 0 0", pend.size(), fl.size(), sys_mem_request);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_burst();
        test_backpressure();
        test_write();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
